axis_arbiter: RTL

AXIS_ARBITER -- requirements
Module: axis_arbiter

---
 rtl/axis_arb_pkg.sv | 16 +
 rtl/axis_if.sv | 28 ++
 rtl/axis_arbiter_rr_select.sv | 29 ++
 rtl/axis_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and limits for the AXI-Stream packet arbiter.
package axis_arb_pkg;

    localparam int MAX_INPUTS = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PASS = 1'b1
    } arb_state_e;

    // Slot reached by stepping 'off' places past 'base' in a ring of n slots.
    function automatic int wrap_idx(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream link with transmitter/receiver views.
interface AXIS_IF #(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 8,
    parameter int TDEST_WIDTH = 8,
    parameter int TUSER_WIDTH = 1
);
    logic                       tvalid;
    logic                       tready;
    logic [TDATA_WIDTH-1:0]     tdata;
    logic [TDATA_WIDTH/8-1:0]   tstrb;
    logic [TDATA_WIDTH/8-1:0]   tkeep;
    logic                       tlast;
    logic [TID_WIDTH-1:0]       tid;
    logic [TDEST_WIDTH-1:0]     tdest;
    logic [TUSER_WIDTH-1:0]     tuser;
    logic                       twakeup;

    modport Transmitter (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
        input  tready
    );

    modport Receiver (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
        output tready
    );
endinterface

// File: rtl/axis_arbiter_rr_select.sv
// Combinational round-robin picker: first requester after last_grant wins.
module rr_select
    import axis_arb_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int IDX_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic [NUM_INPUTS-1:0] req,
    input  logic [IDX_WIDTH-1:0]  last_grant,
    output logic                  valid,
    output logic [IDX_WIDTH-1:0]  index
);

    // Scan upward from last_grant+1, wrapping; last_grant itself is visited last.
    always_comb begin
        int cand;
        cand  = 0;
        valid = 1'b0;
        index = '0;
        for (int off = 1; off <= NUM_INPUTS; off++) begin
            cand = wrap_idx(int'(last_grant), off, NUM_INPUTS);
            if (!valid && req[IDX_WIDTH'(cand)]) begin
                valid = 1'b1;
                index = IDX_WIDTH'(cand);
            end
        end
    end

endmodule

// File: rtl/axis_arbiter.sv
// Packet-level round-robin arbiter merging NUM_INPUTS AXI-Stream sources.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no grant active; all tready low, output quiet; arbitrate
//   PASS  | granted input wired through until its tlast handshake
module axis_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 8,
    parameter int TDEST_WIDTH = 8,
    parameter int TUSER_WIDTH = 1,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    AXIS_IF.Receiver                      s_axis [NUM_INPUTS],
    AXIS_IF.Transmitter                   m_axis,
    output logic [$clog2(NUM_INPUTS)-1:0] grant_idx,
    output logic                          busy,
    output logic [CNT_WIDTH-1:0]          pkt_count
);

    localparam int GW = $clog2(NUM_INPUTS);
    localparam int KW = TDATA_WIDTH / 8;

    logic [NUM_INPUTS-1:0]  s_tvalid;
    logic [NUM_INPUTS-1:0]  s_tlast;
    logic [NUM_INPUTS-1:0]  s_twakeup;
    logic [NUM_INPUTS-1:0]  s_tready;
    logic [TDATA_WIDTH-1:0] s_tdata [NUM_INPUTS];
    logic [KW-1:0]          s_tstrb [NUM_INPUTS];
    logic [KW-1:0]          s_tkeep [NUM_INPUTS];
    logic [TID_WIDTH-1:0]   s_tid   [NUM_INPUTS];
    logic [TDEST_WIDTH-1:0] s_tdest [NUM_INPUTS];
    logic [TUSER_WIDTH-1:0] s_tuser [NUM_INPUTS];

    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_port
        assign s_tvalid[g]      = s_axis[g].tvalid;
        assign s_tlast[g]       = s_axis[g].tlast;
        assign s_twakeup[g]     = s_axis[g].twakeup;
        assign s_tdata[g]       = s_axis[g].tdata;
        assign s_tstrb[g]       = s_axis[g].tstrb;
        assign s_tkeep[g]       = s_axis[g].tkeep;
        assign s_tid[g]         = s_axis[g].tid;
        assign s_tdest[g]       = s_axis[g].tdest;
        assign s_tuser[g]       = s_axis[g].tuser;
        assign s_axis[g].tready = s_tready[g];
    end

    arb_state_e             state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          last_grant_q, last_grant_d;
    logic [CNT_WIDTH-1:0]   pkt_count_q, pkt_count_d;

    logic                   sel_valid;
    logic [GW-1:0]          sel_idx;
    logic                   pkt_done;

    rr_select #(
        .NUM_INPUTS (NUM_INPUTS),
        .IDX_WIDTH  (GW)
    ) u_rr_select (
        .req        (s_tvalid),
        .last_grant (last_grant_q),
        .valid      (sel_valid),
        .index      (sel_idx)
    );

    assign pkt_done = (state_q == PASS) && s_tvalid[grant_q] && s_tlast[grant_q]
                      && m_axis.tready;

    // State, grant and packet counter; reset leaves input 0 first in line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_INPUTS - 1);
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    // Arbitrate in IDLE; in PASS hold the grant until the tlast handshake.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        pkt_count_d  = pkt_count_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = PASS;
                    grant_d = sel_idx;
                end
            end
            PASS: begin
                if (pkt_done) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                    pkt_count_d  = pkt_count_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    logic                   m_tvalid;
    logic [TDATA_WIDTH-1:0] m_tdata;
    logic [KW-1:0]          m_tstrb;
    logic [KW-1:0]          m_tkeep;
    logic                   m_tlast;
    logic [TID_WIDTH-1:0]   m_tid;
    logic [TDEST_WIDTH-1:0] m_tdest;
    logic [TUSER_WIDTH-1:0] m_tuser;
    logic                   m_twakeup;

    // Wire the granted input through in PASS; everything quiet otherwise.
    always_comb begin
        m_tvalid  = 1'b0;
        m_tdata   = '0;
        m_tstrb   = '0;
        m_tkeep   = '0;
        m_tlast   = 1'b0;
        m_tid     = '0;
        m_tdest   = '0;
        m_tuser   = '0;
        m_twakeup = 1'b0;
        s_tready  = '0;
        if (state_q == PASS) begin
            m_tvalid          = s_tvalid[grant_q];
            m_tdata           = s_tdata[grant_q];
            m_tstrb           = s_tstrb[grant_q];
            m_tkeep           = s_tkeep[grant_q];
            m_tlast           = s_tlast[grant_q];
            m_tid             = s_tid[grant_q];
            m_tdest           = s_tdest[grant_q];
            m_tuser           = s_tuser[grant_q];
            m_twakeup         = s_twakeup[grant_q];
            s_tready[grant_q] = m_axis.tready;
        end
    end

    assign m_axis.tvalid  = m_tvalid;
    assign m_axis.tdata   = m_tdata;
    assign m_axis.tstrb   = m_tstrb;
    assign m_axis.tkeep   = m_tkeep;
    assign m_axis.tlast   = m_tlast;
    assign m_axis.tid     = m_tid;
    assign m_axis.tdest   = m_tdest;
    assign m_axis.tuser   = m_tuser;
    assign m_axis.twakeup = m_twakeup;

    assign grant_idx = grant_q;
    assign busy      = (state_q == PASS);
    assign pkt_count = pkt_count_q;

endmodule
